// File: rtl/mor1kx_tlb_reload_arb_pkg.sv
// Shared encodings and the tie-break helper for the IMMU/DMMU TLB-reload arbiter.
package mor1kx_tlb_reload_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_READ = 2'd1,
        ARB_RESP = 2'd2,
        ARB_HOLD = 2'd3
    } arb_state_e;

    localparam logic OWNER_IMMU = 1'b0;
    localparam logic OWNER_DMMU = 1'b1;

    // A tie goes to whichever MMU did not own the previous walk.
    function automatic logic arb_pick(input logic immu_req,
                                      input logic dmmu_req,
                                      input logic last_owner);
        if (immu_req && dmmu_req) begin
            return ~last_owner;
        end
        return dmmu_req ? OWNER_DMMU : OWNER_IMMU;
    endfunction

endpackage

// File: rtl/mor1kx_tlb_reload_arb.sv
// Arbitrates IMMU/DMMU hardware TLB-reload walks onto one Wishbone classic read master.
// Optional bus watchdog enabled by defining MOR1KX_TLB_RELOAD_TIMEOUT_EN.
module mor1kx_tlb_reload_arb
    import mor1kx_tlb_reload_arb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          immu_req_i,
    input  logic [AW-1:0] immu_addr_i,
    output logic          immu_ack_o,
    output logic [AW-1:0] immu_data_o,

    input  logic          dmmu_req_i,
    input  logic [AW-1:0] dmmu_addr_i,
    output logic          dmmu_ack_o,
    output logic [AW-1:0] dmmu_data_o,

    output logic [AW-1:0] wbm_adr_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    input  logic [AW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,

    output logic          busy_o,
    output logic          owner_o,
    output logic          timeout_o
);

    arb_state_e    r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_last_owner, w_last_owner_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic          r_cyc, w_cyc_nxt;
    logic          r_immu_ack, w_immu_ack_nxt;
    logic          r_dmmu_ack, w_dmmu_ack_nxt;
    logic [AW-1:0] r_immu_data, w_immu_data_nxt;
    logic [AW-1:0] r_dmmu_data, w_dmmu_data_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic          r_busy, w_busy_nxt;

    logic          w_owner_req;
    logic          w_owner_ack;
    logic          w_term;
    logic          w_expired;
    logic [AW-1:0] w_rdata;

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

    assign w_owner_req = r_owner ? dmmu_req_i : immu_req_i;
    assign w_owner_ack = r_owner ? r_dmmu_ack : r_immu_ack;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_adr_nxt        = r_adr;
        w_cyc_nxt        = r_cyc;
        w_immu_ack_nxt   = 1'b0;
        w_dmmu_ack_nxt   = 1'b0;
        w_immu_data_nxt  = r_immu_data;
        w_dmmu_data_nxt  = r_dmmu_data;
        w_timeout_nxt    = 1'b0;
        w_term           = 1'b0;
        w_expired        = 1'b0;
        w_rdata          = '0;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
        w_cnt_nxt        = r_cnt;
`endif

        unique case (r_state)
            ARB_IDLE: begin
                if (immu_req_i || dmmu_req_i) begin
                    w_owner_nxt = arb_pick(immu_req_i, dmmu_req_i, r_last_owner);
                    w_adr_nxt   = (w_owner_nxt == OWNER_DMMU) ? dmmu_addr_i : immu_addr_i;
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = ARB_READ;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end

            ARB_READ: begin
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
                w_cnt_nxt = r_cnt + CNT_W'(1);
                w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
                // err outranks ack; a late ack on the expiry cycle still counts.
                if (wbm_err_i) begin
                    w_term = 1'b1;
                end else if (wbm_ack_i) begin
                    w_term  = 1'b1;
                    w_rdata = wbm_dat_i;
                end else if (w_expired) begin
                    w_term        = 1'b1;
                    w_timeout_nxt = 1'b1;
                end

                if (w_term) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ARB_RESP;
                    if (w_owner_req) begin
                        if (r_owner == OWNER_DMMU) begin
                            w_dmmu_ack_nxt  = 1'b1;
                            w_dmmu_data_nxt = w_rdata;
                        end else begin
                            w_immu_ack_nxt  = 1'b1;
                            w_immu_data_nxt = w_rdata;
                        end
                    end
                end
            end

            ARB_RESP: begin
                // No ack pulse means the owner abandoned the walk.
                if (w_owner_ack) begin
                    w_state_nxt = ARB_HOLD;
                end else begin
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = ARB_IDLE;
                end
            end

            ARB_HOLD: begin
                if (w_owner_req) begin
                    w_adr_nxt   = (r_owner == OWNER_DMMU) ? dmmu_addr_i : immu_addr_i;
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = ARB_READ;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end else begin
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = ARB_IDLE;
                end
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ARB_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ARB_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWNER_IMMU;
            r_last_owner <= OWNER_DMMU;
            r_adr        <= '0;
            r_cyc        <= 1'b0;
            r_immu_ack   <= 1'b0;
            r_dmmu_ack   <= 1'b0;
            r_immu_data  <= '0;
            r_dmmu_data  <= '0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_adr        <= w_adr_nxt;
            r_cyc        <= w_cyc_nxt;
            r_immu_ack   <= w_immu_ack_nxt;
            r_dmmu_ack   <= w_dmmu_ack_nxt;
            r_immu_data  <= w_immu_data_nxt;
            r_dmmu_data  <= w_dmmu_data_nxt;
            r_timeout    <= w_timeout_nxt;
            r_busy       <= w_busy_nxt;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
            r_cnt        <= w_cnt_nxt;
`endif
        end
    end

    assign immu_ack_o  = r_immu_ack;
    assign immu_data_o = r_immu_data;
    assign dmmu_ack_o  = r_dmmu_ack;
    assign dmmu_data_o = r_dmmu_data;
    assign wbm_adr_o   = r_adr;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hf;
    assign busy_o      = r_busy;
    assign owner_o     = r_owner;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arb.sv
// Scoreboard bench for mor1kx_tlb_reload_arb; exercises the watchdog when
// MOR1KX_TLB_RELOAD_TIMEOUT_EN is defined.
module tb_mor1kx_tlb_reload_arb;

    localparam int unsigned AW = 32;
`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          immu_req_i, dmmu_req_i;
    logic [AW-1:0] immu_addr_i, dmmu_addr_i;
    logic          immu_ack_o, dmmu_ack_o;
    logic [AW-1:0] immu_data_o, dmmu_data_o;
    logic [AW-1:0] wbm_adr_o, wbm_dat_i;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_ack_i, wbm_err_i;
    logic          busy_o, owner_o, timeout_o;

    typedef struct {
        logic          owner;
        logic [AW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_immu_ack = 0;
    int   n_dmmu_ack = 0;

    always #5 clk = ~clk;

    mor1kx_tlb_reload_arb #(
        .AW             (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .immu_req_i  (immu_req_i),
        .immu_addr_i (immu_addr_i),
        .immu_ack_o  (immu_ack_o),
        .immu_data_o (immu_data_o),
        .dmmu_req_i  (dmmu_req_i),
        .dmmu_addr_i (dmmu_addr_i),
        .dmmu_ack_o  (dmmu_ack_o),
        .dmmu_data_o (dmmu_data_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o),
        .timeout_o   (timeout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the arbiter to start a bus cycle; n = negedges waited.
    task automatic wait_cyc(input string tag, output int n);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (wbm_cyc_o && wbm_stb_o) return;
        end
        check_eq({tag, "_no_cyc"}, 32'(wbm_cyc_o), 32'd1);
    endtask

    // Bus slave for one read; queues the MMU-side response it should cause.
    task automatic bus_read(input string tag, input logic [AW-1:0] exp_adr, input logic exp_owner,
                            input int waits, input logic [AW-1:0] dat, input logic err,
                            input logic deliver, output int n);
        exp_t e;
        wait_cyc(tag, n);
        check_eq({tag, "_adr"}, wbm_adr_o, exp_adr);
        check_eq({tag, "_owner"}, 32'(owner_o), 32'(exp_owner));
        repeat (waits) @(negedge clk);
        wbm_dat_i = dat;
        wbm_ack_i = !err;
        wbm_err_i = err;
        if (deliver) begin
            e.owner = exp_owner;
            e.data  = err ? '0 : dat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
    endtask

    // Every ack pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (immu_ack_o || dmmu_ack_o)) begin
            if (immu_ack_o) n_immu_ack++;
            if (dmmu_ack_o) n_dmmu_ack++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_ack", 32'({immu_ack_o, dmmu_ack_o}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("ack_owner", 32'({immu_ack_o, dmmu_ack_o}), e.owner ? 32'd1 : 32'd2);
                check_eq("ack_data", e.owner ? dmmu_data_o : immu_data_o, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int n;
        int ia;
        int da;
        rst_n       = 1'b0;
        immu_req_i  = 1'b0;
        dmmu_req_i  = 1'b0;
        immu_addr_i = '0;
        dmmu_addr_i = '0;
        wbm_dat_i   = '0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check_eq("rst_stb", 32'(wbm_stb_o), 32'd0);
        check_eq("rst_we", 32'(wbm_we_o), 32'd0);
        check_eq("rst_sel", 32'(wbm_sel_o), 32'hf);
        check_eq("rst_adr", wbm_adr_o, 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_owner", 32'(owner_o), 32'd0);
        check_eq("rst_acks", 32'({immu_ack_o, dmmu_ack_o}), 32'd0);
        check_eq("rst_idata", immu_data_o, 32'd0);
        check_eq("rst_ddata", dmmu_data_o, 32'd0);
        check_eq("rst_timeout", 32'(timeout_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-level DMMU walk on a zero-wait bus.
        ia = n_immu_ack;
        da = n_dmmu_ack;
        dmmu_addr_i = 32'h0000_1004;
        dmmu_req_i  = 1'b1;
        bus_read("t1_rd0", 32'h0000_1004, 1'b1, 0, 32'h0040_2000, 1'b0, 1'b1, n);
        check_eq("t1_grant_lat", 32'(n), 32'd1);
        dmmu_addr_i = 32'h0040_2008;
        bus_read("t1_rd1", 32'h0040_2008, 1'b1, 0, 32'h1234_A7C3, 1'b0, 1'b1, n);
        check_eq("t1_restart_lat", 32'(n), 32'd2);
        dmmu_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t1_idle", 32'(busy_o), 32'd0);
        check_eq("t1_dmmu_acks", 32'(n_dmmu_ack - da), 32'd2);
        check_eq("t1_immu_acks", 32'(n_immu_ack - ia), 32'd0);
        check_eq("t1_data_hold", dmmu_data_o, 32'h1234_A7C3);

        // Simultaneous requests straight out of reset: IMMU walk is atomic.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        immu_addr_i = 32'h2000_0100;
        dmmu_addr_i = 32'h3000_0200;
        immu_req_i  = 1'b1;
        dmmu_req_i  = 1'b1;
        bus_read("t2_i0", 32'h2000_0100, 1'b0, 1, 32'hAAAA_0001, 1'b0, 1'b1, n);
        immu_addr_i = 32'h2000_0104;
        bus_read("t2_i1", 32'h2000_0104, 1'b0, 0, 32'hAAAA_0002, 1'b0, 1'b1, n);
        check_eq("t2_walk_locked", 32'(n), 32'd2);
        immu_req_i = 1'b0;
        bus_read("t2_d0", 32'h3000_0200, 1'b1, 0, 32'hBBBB_0003, 1'b0, 1'b1, n);
        check_eq("t2_handover_lat", 32'(n), 32'd3);
        dmmu_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t2_immu_hold", immu_data_o, 32'hAAAA_0002);

        // Bus error on the second read returns zero data.
        dmmu_addr_i = 32'h4000_0000;
        dmmu_req_i  = 1'b1;
        bus_read("t3_rd0", 32'h4000_0000, 1'b1, 2, 32'h5555_0000, 1'b0, 1'b1, n);
        dmmu_addr_i = 32'h4000_0004;
        bus_read("t3_rd1", 32'h4000_0004, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 1'b1, n);
        dmmu_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t3_err_data", dmmu_data_o, 32'h0000_0000);

        // DMMU drops its request during a 3-wait read; pending IMMU goes next.
        dmmu_addr_i = 32'h6000_0010;
        dmmu_req_i  = 1'b1;
        wait_cyc("t4_d0", n);
        check_eq("t4_d0_adr", wbm_adr_o, 32'h6000_0010);
        check_eq("t4_d0_owner", 32'(owner_o), 32'd1);
        immu_addr_i = 32'h7000_0020;
        immu_req_i  = 1'b1;
        @(negedge clk);
        dmmu_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t4_cyc_held", 32'(wbm_cyc_o), 32'd1);
        wbm_dat_i = 32'hDEAD_BEEF;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        bus_read("t4_i0", 32'h7000_0020, 1'b0, 0, 32'h1111_2222, 1'b0, 1'b1, n);
        check_eq("t4_regrant_lat", 32'(n), 32'd2);
        immu_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t4_discarded", dmmu_data_o, 32'h0000_0000);

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
        // Silent bus: watchdog terminates after TO READ cycles.
        begin
            exp_t e;
            int   c;
            immu_addr_i = 32'h8000_0000;
            immu_req_i  = 1'b1;
            wait_cyc("t5", n);
            e.owner = 1'b0;
            e.data  = '0;
            sb_q.push_back(e);
            c = 1;
            while (c < 40) begin
                @(negedge clk);
                if (!wbm_cyc_o) break;
                c++;
            end
            check_eq("t5_read_cycles", 32'(c), 32'(TO));
            check_eq("t5_timeout_pulse", 32'(timeout_o), 32'd1);
            immu_req_i = 1'b0;
            @(negedge clk);
            check_eq("t5_timeout_once", 32'(timeout_o), 32'd0);
            repeat (3) @(negedge clk);
        end
`else
        check_eq("t5_timeout_tied", 32'(timeout_o), 32'd0);
`endif

        // Asynchronous reset in the middle of a READ.
        immu_addr_i = 32'h9000_0040;
        immu_req_i  = 1'b1;
        wait_cyc("t6", n);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_cyc", 32'(wbm_cyc_o), 32'd0);
        check_eq("t6_stb", 32'(wbm_stb_o), 32'd0);
        check_eq("t6_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read("t6_i0", 32'h9000_0040, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, n);
        check_eq("t6_rearb_lat", 32'(n), 32'd1);
        immu_req_i = 1'b0;
        repeat (4) @(negedge clk);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
